// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Register-file write-port arbiter between the pipeline
//                writeback stage (WB) and a long-latency unit (LU).
//                At most one nonzero-rd write is forwarded per cycle on
//                we3/a3/wd3. The outputs are combinational, so the register
//                file commits on the falling edge of the same cycle.
//                WB is preferred. The LU wins in two cases:
//                  - after STARVE_MAX consecutive lost cycles, or
//                  - when both target the same rd. The older LU result is
//                    written first, and the WB write follows next cycle.
//                A request with rd==0 is accepted at once and is never
//                written.
//                An optional pending-write scoreboard answers source-operand
//                hazard queries for registers that still await an LU result.
//  Options     : `define WBARB_SCOREBOARD_EN to build the pending scoreboard
//                and the rs1_busy/rs2_busy hazard outputs. When it is
//                undefined, both busy outputs are tied to 0 and
//                lu_issue/lu_issue_rd are ignored.
//  Ports       : clk, reset              - clock, sync active-high reset
//                wb_valid/wb_rd/wb_data  - writeback request
//                stall_wb                - WB not accepted this cycle
//                lu_valid/lu_rd/lu_data  - LU result request
//                lu_ready                - LU result accepted this cycle
//                lu_issue/lu_issue_rd    - LU op dispatched, its rd
//                we3/a3/wd3              - register-file write port
//                rs1/rs2                 - hazard query sources
//                rs1_busy/rs2_busy       - LU write pending on that source
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  // pipeline writeback
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall_wb,
  // long-latency unit result
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  // long-latency unit issue
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_rd,
  // register-file write port
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3,
  // hazard query
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy
);

  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

  // --------------------------------------------------------------------------
  // Arbitration (combinational)
  // --------------------------------------------------------------------------
  logic       w_wb_req;     // WB wants the write port
  logic       w_lu_req;     // LU wants the write port
  logic       w_lu_grant;   // LU owns the write port this cycle
  logic       w_wb_grant;   // WB owns the write port this cycle
  logic [3:0] starve_q;
  logic [3:0] starve_d;

  // Requests that target x0 never compete for the port.
  assign w_wb_req = wb_valid && (wb_rd != 5'd0);
  assign w_lu_req = lu_valid && (lu_rd != 5'd0);

  assign w_lu_grant = w_lu_req &&
                      (!w_wb_req || (starve_q == c_STARVE_MAX) || (wb_rd == lu_rd));
  assign w_wb_grant = w_wb_req && !w_lu_grant;

  always_comb begin
    we3      = 1'b0;
    a3       = 5'd0;
    wd3      = 32'd0;
    stall_wb = 1'b0;
    lu_ready = 1'b0;
    if (!reset) begin
      // rd==0 LU results are acknowledged at once without a write.
      lu_ready = lu_valid && ((lu_rd == 5'd0) || w_lu_grant);
      stall_wb = w_wb_req && w_lu_grant;
      if (w_lu_grant) begin
        we3 = 1'b1;
        a3  = lu_rd;
        wd3 = lu_data;
      end else if (w_wb_grant) begin
        we3 = 1'b1;
        a3  = wb_rd;
        wd3 = wb_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Starvation counter: counts consecutive cycles in which the LU is waiting
  // but not accepted. It saturates at the threshold, so the LU keeps
  // priority until it is served.
  // --------------------------------------------------------------------------
  always_comb begin
    starve_d = starve_q;
    if (!lu_valid || lu_ready) begin
      starve_d = 4'd0;
    end else if (starve_q < c_STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

`ifdef WBARB_SCOREBOARD_EN
  // --------------------------------------------------------------------------
  // Pending-write scoreboard. The set is applied after the clear, so that a
  // new issue to the same rd as a retiring result keeps the bit busy.
  // --------------------------------------------------------------------------
  logic [31:0] pending_q;
  logic [31:0] pending_d;
  logic        w_lu_done;

  assign w_lu_done = lu_valid && lu_ready;

  always_comb begin
    pending_d = pending_q;
    if (w_lu_done) begin
      pending_d[lu_rd] = 1'b0;
    end
    if (lu_issue && (lu_issue_rd != 5'd0)) begin
      pending_d[lu_issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 32'd0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // The busy outputs report the registered state only. An issue or a
  // retirement in the current cycle shows up from the next cycle on.
  assign rs1_busy = pending_q[rs1];
  assign rs2_busy = pending_q[rs2];
`else
  // Without the scoreboard, the issue and query inputs have no function.
  logic w_sb_unused;
  assign w_sb_unused = ^{lu_issue, lu_issue_rd, rs1, rs2};
  assign rs1_busy    = 1'b0;
  assign rs2_busy    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive lost arbitration cycles after which the long-latency unit (LU) wins over pipeline writeback (WB); legal range 1..15.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have WB ports: wb_valid  in  1  writeback request; wb_rd  in  5  destination register; wb_data  in  32  write data; stall_wb  out  1  WB not accepted this cycle, pipeline holds its WB stage.
REQ-004 SHALL have LU ports: lu_valid  in  1  result request; lu_rd  in  5  destination register; lu_data  in  32  result data; lu_ready  out  1  result accepted this cycle.
REQ-005 SHALL have LU issue ports: lu_issue  in  1  LU op dispatched; lu_issue_rd  in  5  its destination register.
REQ-006 SHALL have register-file write port outputs: we3  out  1  write enable; a3  out  5  write address; wd3  out  32  write data.
REQ-007 SHALL have hazard query ports: rs1, rs2  in  5  source registers; rs1_busy, rs2_busy  out  1  source has an LU write pending.

Function
REQ-008 SHALL drive at most one nonzero-rd write per cycle on we3/a3/wd3; outputs combinational from the current request, so the register file commits on the falling edge of the same cycle (zero-cycle latency).
REQ-009 SHALL complete an LU transfer on a rising edge with lu_valid && lu_ready; the LU holds lu_rd/lu_data stable while lu_valid && !lu_ready.
REQ-010 SHALL accept WB in any cycle with wb_valid && !stall_wb; stall_wb SHALL be 0 whenever wb_valid is 0.
REQ-011 SHALL accept a request with rd==0 immediately without occupying the port (we3 not asserted for it), so an rd==0 request never stalls and never blocks the other requester.
REQ-012 Arbitration, nonzero rd on both: default WB granted, lu_ready=0; LU granted (stall_wb=1) when starve count == STARVE_MAX or when wb_rd == lu_rd (older LU result written first, younger WB next cycle).
REQ-013 Only one requester valid (nonzero rd): that requester is granted, no stall.
REQ-014 Starve counter (4-bit): increments, saturating at STARVE_MAX, on each cycle lu_valid=1 and LU not granted; clears to 0 on LU grant or when lu_valid=0.
REQ-015 Scoreboard: 32-bit pending vector; lu_issue with lu_issue_rd!=0 sets bit lu_issue_rd; completed LU transfer clears bit lu_rd; simultaneous set and clear of the same bit SHALL leave it set; bit 0 always 0.
REQ-016 rs1_busy = pending[rs1], rs2_busy = pending[rs2], combinational, reflecting register state (not same-cycle set/clear).
REQ-017 On no grant: we3=0, a3=0, wd3=0.

Reset
REQ-018 While reset=1: we3=0, a3=0, wd3=0, lu_ready=0, stall_wb=0; no write forwarded regardless of requests.
REQ-019 On the rising edge with reset=1: starve counter cleared to 0, pending vector cleared to 0; reset mid-transfer drops the in-flight LU request without acknowledgement.
REQ-020 First cycle after reset deassertion SHALL arbitrate normally.

Configuration
REQ-021 Macro WBARB_SCOREBOARD_EN: defined -> pending vector and rs1_busy/rs2_busy per REQ-015/016; undefined -> no pending storage, rs1_busy=rs2_busy=0, lu_issue/lu_issue_rd ignored; arbitration unchanged.

Verification
REQ-022 WB only: wb_valid=1, wb_rd=5, wb_data=A5A5A5A5 -> same cycle we3=1, a3=5, wd3=A5A5A5A5, stall_wb=0; read-back x5 = A5A5A5A5.
REQ-023 Starvation, STARVE_MAX=4: wb_valid held with distinct rd (1..), lu_valid=1 lu_rd=10 lu_data=12345678 -> WB wins 4 cycles, cycle 5 a3=10, wd3=12345678, lu_ready=1, stall_wb=1; counter back to 0.
REQ-024 Same-rd conflict: wb_rd=lu_rd=7, wb_data=11111111, lu_data=22222222 -> cycle 1 LU written, stall_wb=1; cycle 2 WB written; x7 reads 11111111.
REQ-025 x0: wb_rd=0 wb_data=FFFFFFFF with lu_rd=3 valid -> we3 writes x3 only, both accepted same cycle, stall_wb=0; x0 reads 0.
REQ-026 Scoreboard (macro defined): lu_issue rd=9, rs1=9 -> rs1_busy=1 next cycle; LU completes rd=9 while lu_issue rd=9 again -> busy stays 1; macro undefined -> rs1_busy=0 throughout.
REQ-027 Reset mid-op: pending bit 9 set, lu_valid=1 starving at count 3, reset=1 one cycle -> lu_ready=0, we3=0 during reset; afterward count 0, rs1_busy=0.
